sound_player: RTL and testbench

Consumes the game-state sound request (`playsound` + 2-bit `soundselector`) and plays the selected short melody as a square wave on a single speaker pin. It sits between the game-state FSM and the board audio output. Each sound is a fixed sequence of 1–4 notes, with a silent gap after every note. A new request may preempt the sound that is playing, based on priority.

---
 rtl/frogger_pkg.sv | 8 +
 rtl/tone_gen.sv | 28 ++
 rtl/sound_player.sv | 96 +++++++++
 tb/tb_sound_player.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// frogger_pkg: sound codes and player states shared with the game-state FSM
package frogger_pkg;
  typedef enum logic [1:0] {UI_PRESS, NEXTLEVEL, CRASH, CELEBRATION} soundtype_t;
  typedef enum logic [1:0] {IDLE, TONE, GAP} player_state_t;
  function automatic logic [1:0] last_note(input soundtype_t s);
    return s == CELEBRATION ? 2'd3 : s == UI_PRESS ? 2'd0 : 2'd2;
  endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave divider, restarts low on load, held low when disabled
module tone_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] half_period,
  output logic         wave
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (load) begin
      cnt  <= half_period - 1'b1;
      wave <= 1'b0;
    end else if (!en) begin
      wave <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= half_period - 1'b1;
      wave <= ~wave;
    end else begin
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/sound_player.sv
// sound_player: plays prioritised note sequences as a square wave on one pin
module sound_player
  import frogger_pkg::*;
#(
  parameter int CLK_HZ      = 48_000_000,
  parameter int NOTE_CYCLES = 4_800_000,
  parameter int GAP_CYCLES  = 480_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       playsound,
  input  logic [1:0] soundselector,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] cur_sound
);
  localparam int TW = $clog2(CLK_HZ / 392) + 1;
  localparam int DW = $clog2(NOTE_CYCLES > GAP_CYCLES ? NOTE_CYCLES : GAP_CYCLES) + 1;
  localparam logic [DW-1:0] NOTE_LD = DW'(NOTE_CYCLES - 1);
  localparam logic [DW-1:0] GAP_LD  = DW'(GAP_CYCLES - 1);
  function automatic logic [TW-1:0] hp_of(input int f);
    int h;
    h = CLK_HZ / (2 * f);
    return TW'(h < 1 ? 1 : h);
  endfunction
  // indexed by {sound, note}; short sounds repeat their last entry
  localparam logic [TW-1:0] HP_TAB [16] = '{
    hp_of(880), hp_of(880), hp_of(880), hp_of(880),
    hp_of(523), hp_of(659), hp_of(784), hp_of(784),
    hp_of(392), hp_of(311), hp_of(196), hp_of(196),
    hp_of(523), hp_of(659), hp_of(784), hp_of(1047)};
  player_state_t state, state_n;
  soundtype_t    cur_q, cur_n, code_q;
  logic [1:0]    idx, idx_n;
  logic [DW-1:0] dur, dur_n;
  logic          prev_ps, armed, req, rise, start, load;
  // armed blocks a level that was already high when reset released
  assign rise  = playsound & ~prev_ps & armed;
  assign start = req && (state == IDLE || code_q >= cur_q);
  always_comb begin
    state_n = state;
    cur_n   = cur_q;
    idx_n   = idx;
    dur_n   = dur;
    load    = 1'b0;
    if (start) begin
      state_n = TONE;
      cur_n   = code_q;
      idx_n   = 2'd0;
      dur_n   = NOTE_LD;
      load    = 1'b1;
    end else if (state == TONE) begin
      state_n = dur == '0 ? GAP : TONE;
      dur_n   = dur == '0 ? GAP_LD : dur - 1'b1;
    end else if (state == GAP && dur != '0) begin
      dur_n = dur - 1'b1;
    end else if (state == GAP && idx == last_note(cur_q)) begin
      state_n = IDLE;
    end else if (state == GAP) begin
      state_n = TONE;
      idx_n   = idx + 2'd1;
      dur_n   = NOTE_LD;
      load    = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev_ps <= 1'b0;
      armed   <= 1'b0;
      req     <= 1'b0;
      code_q  <= UI_PRESS;
      state   <= IDLE;
      cur_q   <= UI_PRESS;
      idx     <= '0;
      dur     <= '0;
    end else begin
      prev_ps <= playsound;
      armed   <= armed | ~playsound;
      req     <= rise;
      if (rise) code_q <= soundtype_t'(soundselector);
      state <= state_n;
      cur_q <= cur_n;
      idx   <= idx_n;
      dur   <= dur_n;
    end
  tone_gen #(.W(TW)) u_tone (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (state_n == TONE),
    .load       (load),
    .half_period(HP_TAB[{cur_n, idx_n}]),
    .wave       (speaker)
  );
  assign busy      = state != IDLE;
  assign cur_sound = cur_q;
endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: table vectors, corner sequences and random requests vs. a timeline model
module tb_sound_player;
  localparam int CLK = 20_000, NOTE = 200, GAP = 20;
  logic clk = 1'b0, reset_n = 1'b0, playsound = 1'b0;
  logic [1:0] soundselector = 2'd0;
  logic speaker, busy;
  logic [1:0] cur_sound;
  int n_chk = 0, n_fail = 0, cyc = 0, bsy_cnt = 0, hp_seen = 0;
  int FREQ [4][4] = '{'{880, 0, 0, 0}, '{523, 659, 784, 0}, '{392, 311, 196, 0}, '{523, 659, 784, 1047}};
  int NN [4] = '{1, 3, 3, 4};
  // model: a sound is a timeline position k since its first TONE edge
  int m_last = -1, m_pcode = 0, m_code = 0, m_k = 0;
  bit m_pend = 0, m_act = 0;
  typedef struct {int code; int busy_len; int hp;} vec_t;
  vec_t tv [4];

  sound_player #(.CLK_HZ(CLK), .NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .playsound(playsound), .soundselector(soundselector),
    .speaker(speaker), .busy(busy), .cur_sound(cur_sound));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last = -1; m_pend = 0; m_act = 0; m_code = 0; m_k = 0; m_pcode = 0;
  endtask

  task automatic model_edge();
    bit was;
    was = m_act;
    if (m_act) begin
      m_k++;
      if (m_k == NN[m_code] * (NOTE + GAP)) m_act = 0;
    end
    if (m_pend && (!was || m_pcode >= m_code)) begin
      m_act = 1; m_code = m_pcode; m_k = 0;
    end
    m_pend  = playsound && m_last == 0;
    m_pcode = int'(soundselector);
    m_last  = int'(playsound);
  endtask

  function automatic int exp_spk();
    int r, n, hp;
    if (!m_act) return 0;
    r = m_k % (NOTE + GAP);
    n = m_k / (NOTE + GAP);
    hp = CLK / (2 * FREQ[m_code][n]);
    return r < NOTE ? (r / hp) % 2 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    cyc++;
    if (busy) bsy_cnt++;
    if (busy && speaker && hp_seen == 0) hp_seen = bsy_cnt;
    chk("speaker", int'(speaker), exp_spk());
    chk("busy", int'(busy), int'(m_act));
    chk("cur_sound", int'(cur_sound), m_code);
  endtask

  task automatic play(input int code);
    soundselector = 2'(code);
    playsound = 1'b1;
    tick();
    playsound = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!busy) return;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    tv[0] = '{0, 220, 11};
    tv[1] = '{1, 660, 19};
    tv[2] = '{2, 660, 25};
    tv[3] = '{3, 880, 19};
    repeat (3) tick();
    chk("rst_speaker", int'(speaker), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur", int'(cur_sound), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      bsy_cnt = 0; hp_seen = 0;
      play(tv[i].code);
      wait_idle();
      chk("busy_len", bsy_cnt, tv[i].busy_len);
      chk("first_hp", hp_seen - 1, tv[i].hp);
      repeat (5) tick();
    end
    // preemption up: CRASH restarts 50 clocks into NEXTLEVEL
    bsy_cnt = 0;
    play(1);
    tick();
    repeat (49) tick();
    play(2);
    wait_idle();
    chk("preempt_up_len", bsy_cnt, 711);
    repeat (5) tick();
    // lower priority request ignored
    bsy_cnt = 0;
    play(2);
    repeat (100) tick();
    play(0);
    wait_idle();
    chk("preempt_ign_len", bsy_cnt, 660);
    repeat (5) tick();
    // held level plays once
    bsy_cnt = 0;
    soundselector = 2'd2;
    playsound = 1'b1;
    repeat (2000) tick();
    chk("held_len", bsy_cnt, 660);
    // async reset mid-tone
    playsound = 1'b0;
    tick();
    playsound = 1'b1;
    repeat (31) tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_speaker", int'(speaker), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_cur", int'(cur_sound), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bsy_cnt = 0;
    repeat (50) tick();
    chk("no_restart", bsy_cnt, 0);
    playsound = 1'b0;
    repeat (3) tick();
    // request in the final GAP cycle
    bsy_cnt = 0;
    play(0);
    tick();
    repeat (218) tick();
    play(1);
    wait_idle();
    chk("final_gap_len", bsy_cnt, 880);
    repeat (5) tick();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 400)) tick();
      soundselector = 2'($urandom);
      playsound = 1'b1;
      repeat ($urandom_range(1, 4)) tick();
      playsound = 1'b0;
    end
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
